// File: rtl/regfile_port_ctrl_if.sv
// Signal bundle between regfile_port_ctrl, the ID-stage register file, WB and the debug port.
// The controller uses the slave view; whoever drives WB, decode and debug uses the master view.
interface regfile_port_ctrl_if;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic [4:0]  A1D;
    logic [31:0] RD1;
    logic [4:0]  A1;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        stall_id;
    logic        init_busy;
    logic        dbg_req;
    logic        dbg_we;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;

    modport slave (
        input  RegWriteW, RdW, ResultW, A1D, RD1,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output A1, rf_we, rf_waddr, rf_wdata, stall_id, init_busy,
        output dbg_ack, dbg_rdata
    );

    modport master (
        output RegWriteW, RdW, ResultW, A1D, RD1,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  A1, rf_we, rf_waddr, rf_wdata, stall_id, init_busy,
        input  dbg_ack, dbg_rdata
    );
endinterface

// File: rtl/regfile_port_ctrl.sv
// Register-file write-port owner and debug access controller for the RV32I ID stage.
// Define REGFILE_CLEAR_EN to add the post-reset clear of x1..x31 (CLEAR state and counter).
module regfile_port_ctrl #(
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic               clk,
    input  logic               rst,
    regfile_port_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
`ifdef REGFILE_CLEAR_EN
        CLEAR = 2'd0,
`endif
        IDLE  = 2'd1,
        DRD   = 2'd2,
        ACK   = 2'd3
    } state_t;

`ifdef REGFILE_CLEAR_EN
    localparam state_t RESET_STATE = CLEAR;
`else
    localparam state_t RESET_STATE = IDLE;
`endif

    localparam logic [7:0] STARVE_LIMIT = 8'(STARVE_MAX);

    state_t      r_state;
    state_t      w_next_state;
    logic [7:0]  r_starve;
    logic [7:0]  w_next_starve;
    logic        r_dbg_ack;
    logic [31:0] r_dbg_rdata;

    logic        w_init_busy;
    logic        w_wb_valid;
    logic        w_dbg_wr_req;
    logic        w_dbg_rd_req;
    logic        w_grant;
    logic        w_starved;
    logic        w_rf_we;
    logic [4:0]  w_rf_waddr;
    logic [31:0] w_rf_wdata;

    assign w_wb_valid   = bus.RegWriteW & (bus.RdW != 5'd0);
    assign w_dbg_wr_req = bus.dbg_req & bus.dbg_we;
    assign w_dbg_rd_req = bus.dbg_req & ~bus.dbg_we;
    assign w_starved    = (r_starve == STARVE_LIMIT);

`ifdef REGFILE_CLEAR_EN
    logic [4:0] r_cnt;
    logic       r_init_busy;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt       <= 5'd1;
            r_init_busy <= 1'b1;
        end else begin
            if (r_state == CLEAR) begin
                r_cnt <= r_cnt + 5'd1;
            end
            r_init_busy <= (w_next_state == CLEAR);
        end
    end

    assign w_init_busy = r_init_busy;
`else
    assign w_init_busy = 1'b0;
`endif

    // WB owns the write port by default; CLEAR and an IDLE debug-write grant override it.
    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        w_rf_we      = w_wb_valid;
        w_rf_waddr   = bus.RdW;
        w_rf_wdata   = bus.ResultW;
        case (r_state)
`ifdef REGFILE_CLEAR_EN
            CLEAR: begin
                w_rf_we    = 1'b1;
                w_rf_waddr = r_cnt;
                w_rf_wdata = 32'd0;
                if (r_cnt == 5'd31) begin
                    w_next_state = IDLE;
                end
            end
`endif
            IDLE: begin
                if (!w_wb_valid && w_dbg_wr_req) begin
                    w_grant      = 1'b1;
                    w_rf_we      = (bus.dbg_addr != 5'd0);
                    w_rf_waddr   = bus.dbg_addr;
                    w_rf_wdata   = bus.dbg_wdata;
                    w_next_state = ACK;
                end
                if (w_dbg_rd_req) begin
                    w_next_state = DRD;
                end
            end
            DRD:     w_next_state = ACK;
            ACK:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_next_starve = r_starve;
        if (w_grant) begin
            w_next_starve = 8'd0;
        end else if ((r_state == IDLE) && w_dbg_wr_req && w_wb_valid && !w_starved) begin
            w_next_starve = r_starve + 8'd1;
        end
    end

    // The register file has no bypass, so RD1 in DRD is the pre-write value of that cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= RESET_STATE;
            r_starve    <= 8'd0;
            r_dbg_ack   <= 1'b0;
            r_dbg_rdata <= 32'd0;
        end else begin
            r_state   <= w_next_state;
            r_starve  <= w_next_starve;
            r_dbg_ack <= (w_next_state == ACK);
            if (r_state == DRD) begin
                r_dbg_rdata <= bus.RD1;
            end
        end
    end

    assign bus.rf_we     = w_rf_we & rst;
    assign bus.rf_waddr  = w_rf_waddr;
    assign bus.rf_wdata  = w_rf_wdata;
    assign bus.A1        = (r_state == DRD) ? bus.dbg_addr : bus.A1D;
    assign bus.stall_id  = w_init_busy | (r_state == DRD) | w_starved;
    assign bus.init_busy = w_init_busy;
    assign bus.dbg_ack   = r_dbg_ack;
    assign bus.dbg_rdata = r_dbg_rdata;

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Self-checking bench for regfile_port_ctrl: directed scenarios plus randomized WB/debug traffic
// checked every cycle against a transaction-level model of the port rules.
module tb_regfile_port_ctrl;

    localparam int STARVE_MAX = 8;
`ifdef REGFILE_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   numChecks;
    int   numErrors;

    regfile_port_ctrl_if busIf ();

    regfile_port_ctrl #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (busIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] initVal(input int i);
        return (i == 0) ? 32'd0 : 32'h9E37_79B9 * 32'(i + 1);
    endfunction

    // Behavioural register file: synchronous write, combinational read, x0 hardwired to zero.
    logic [31:0] regs [32];
    initial begin
        for (int i = 0; i < 32; i++) regs[i] <= initVal(i);
        forever begin
            @(posedge clk);
            if (busIf.rf_we === 1'b1 && busIf.rf_waddr != 5'd0) regs[busIf.rf_waddr] <= busIf.rf_wdata;
        end
    end
    assign busIf.RD1 = (busIf.A1 == 5'd0) ? 32'd0 : regs[busIf.A1];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numErrors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: per-cycle expectations from the port rules, advanced on the falling edge.
    bit          mValid = 1'b0;
    int          mClearStep;
    bit          mReadNow;
    bit          mAckNow;
    int          mStarve;
    logic [31:0] mRdata;
    logic [31:0] mRegs [32];

    always @(negedge clk) begin : model
        bit          idle, wbValid, dbgWr, dbgRd, expWe;
        logic [4:0]  expAddr;
        logic [31:0] expData, captured;
        idle    = mValid && (mClearStep == 0) && !mReadNow && !mAckNow;
        wbValid = busIf.RegWriteW && (busIf.RdW != 5'd0);
        dbgWr   = busIf.dbg_req && busIf.dbg_we;
        dbgRd   = busIf.dbg_req && !busIf.dbg_we;
        expWe = 1'b0; expAddr = 5'd0; expData = 32'd0;
        if (mClearStep != 0) begin
            expWe = 1'b1; expAddr = 5'(mClearStep); expData = 32'd0;
        end else if (wbValid) begin
            expWe = 1'b1; expAddr = busIf.RdW; expData = busIf.ResultW;
        end else if (idle && dbgWr) begin
            expWe = (busIf.dbg_addr != 5'd0); expAddr = busIf.dbg_addr; expData = busIf.dbg_wdata;
        end
        if (!rst) expWe = 1'b0;

        if (mValid) begin
            checkOutput("rf_we", 32'(busIf.rf_we), 32'(expWe));
            if (expWe) begin
                checkOutput("rf_waddr", 32'(busIf.rf_waddr), 32'(expAddr));
                checkOutput("rf_wdata", busIf.rf_wdata, expData);
            end
            checkOutput("A1", 32'(busIf.A1), 32'(mReadNow ? busIf.dbg_addr : busIf.A1D));
            checkOutput("stall_id", 32'(busIf.stall_id),
                        32'((mClearStep != 0) || mReadNow || (mStarve == STARVE_MAX)));
            checkOutput("init_busy", 32'(busIf.init_busy), 32'(mClearStep != 0));
            checkOutput("dbg_ack", 32'(busIf.dbg_ack), 32'(mAckNow));
            checkOutput("dbg_rdata", busIf.dbg_rdata, mRdata);
        end

        if (!rst) begin
            if (!mValid) begin
                for (int i = 0; i < 32; i++) mRegs[i] = initVal(i);
            end
            mValid     = 1'b1;
            mClearStep = CLEAR_EN ? 1 : 0;
            mReadNow   = 1'b0;
            mAckNow    = 1'b0;
            mStarve    = 0;
            mRdata     = 32'd0;
        end else if (mValid) begin
            captured = mReadNow ? mRegs[busIf.dbg_addr] : mRdata;
            if (expWe && expAddr != 5'd0) mRegs[expAddr] = expData;
            if (idle && dbgWr) mStarve = wbValid ? ((mStarve < STARVE_MAX) ? mStarve + 1 : mStarve) : 0;
            mAckNow  = mReadNow || (idle && dbgWr && !wbValid);
            mReadNow = idle && dbgRd;
            mRdata   = captured;
            if (mClearStep == 31) mClearStep = 0;
            else if (mClearStep != 0) mClearStep++;
        end
    end

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input bit wbWe, input logic [4:0] rd, input logic [31:0] result,
                                 input bit req, input bit dwe, input logic [4:0] daddr,
                                 input logic [31:0] dwdata);
        busIf.RegWriteW = wbWe;
        busIf.RdW       = rd;
        busIf.ResultW   = result;
        busIf.dbg_req   = req;
        busIf.dbg_we    = dwe;
        busIf.dbg_addr  = daddr;
        busIf.dbg_wdata = dwdata;
    endtask

    task automatic doDebug(input bit dwe, input logic [4:0] daddr, input logic [31:0] dwdata,
                           output logic [31:0] rdata);
        int waited = 0;
        stepCycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, dwe, daddr, dwdata);
        settle();
        while (busIf.dbg_ack !== 1'b1 && waited < 100) begin
            stepCycle();
            settle();
            waited++;
        end
        checkOutput("dbg_ack within bound", 32'(busIf.dbg_ack), 32'd1);
        rdata = busIf.dbg_rdata;
        stepCycle();
        busIf.dbg_req = 1'b0;
        settle();
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected finish before 1000000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic [31:0] rd;
        bit          active, sawAck, burst;
        int          waitCnt;
        numChecks = 0;
        numErrors = 0;
        rst = 1'b0;
        busIf.A1D = 5'd0;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        stepCycle();
        stepCycle();
        settle();
        checkOutput("reset init_busy", 32'(busIf.init_busy), 32'(CLEAR_EN));
        checkOutput("reset dbg_ack", 32'(busIf.dbg_ack), 32'd0);
        checkOutput("reset dbg_rdata", busIf.dbg_rdata, 32'd0);
        checkOutput("reset rf_we", 32'(busIf.rf_we), 32'd0);

`ifdef REGFILE_CLEAR_EN
        stepCycle();
        rst = 1'b1;
        for (int s = 1; s <= 9; s++) begin
            settle();
            checkOutput("pre-abort clear addr", 32'(busIf.rf_waddr), 32'(s));
            stepCycle();
        end
        rst = 1'b0;
        settle();
        checkOutput("abort rf_we", 32'(busIf.rf_we), 32'd0);
        stepCycle();
        rst = 1'b1;
        for (int s = 1; s <= 31; s++) begin
            settle();
            checkOutput("clear rf_we", 32'(busIf.rf_we), 32'd1);
            checkOutput("clear addr", 32'(busIf.rf_waddr), 32'(s));
            checkOutput("clear data", busIf.rf_wdata, 32'd0);
            checkOutput("clear init_busy", 32'(busIf.init_busy), 32'd1);
            stepCycle();
        end
        settle();
`else
        stepCycle();
        rst = 1'b1;
        settle();
`endif
        checkOutput("idle init_busy", 32'(busIf.init_busy), 32'd0);
        checkOutput("idle stall_id", 32'(busIf.stall_id), 32'd0);

        // WB and a debug write collide: WB first, debug write the next free cycle.
        stepCycle();
        applyStimulus(1'b1, 5'd5, 32'hAAAA0000, 1'b1, 1'b1, 5'd6, 32'h1234);
        settle();
        checkOutput("arb wb addr", 32'(busIf.rf_waddr), 32'd5);
        checkOutput("arb wb data", busIf.rf_wdata, 32'hAAAA0000);
        stepCycle();
        busIf.RegWriteW = 1'b0;
        settle();
        checkOutput("arb dbg we", 32'(busIf.rf_we), 32'd1);
        checkOutput("arb dbg addr", 32'(busIf.rf_waddr), 32'd6);
        checkOutput("arb dbg data", busIf.rf_wdata, 32'h1234);
        stepCycle();
        settle();
        checkOutput("arb ack", 32'(busIf.dbg_ack), 32'd1);
        stepCycle();
        busIf.dbg_req = 1'b0;
        settle();
        checkOutput("model x5", mRegs[5], 32'hAAAA0000);
        checkOutput("model x6", mRegs[6], 32'h1234);

        // Debug read of x7 while WB overwrites x7 in the DRD cycle returns the old value.
        stepCycle();
        applyStimulus(1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 1'b0, 5'd0, 32'd0);
        settle();
        stepCycle();
        busIf.A1D = 5'd3;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd7, 32'd0);
        settle();
        checkOutput("read k A1", 32'(busIf.A1), 32'd3);
        stepCycle();
        applyStimulus(1'b1, 5'd7, 32'h11111111, 1'b1, 1'b0, 5'd7, 32'd0);
        settle();
        checkOutput("read k+1 A1", 32'(busIf.A1), 32'd7);
        checkOutput("read k+1 stall", 32'(busIf.stall_id), 32'd1);
        stepCycle();
        busIf.RegWriteW = 1'b0;
        settle();
        checkOutput("read k+2 ack", 32'(busIf.dbg_ack), 32'd1);
        checkOutput("read k+2 rdata", busIf.dbg_rdata, 32'hDEADBEEF);
        stepCycle();
        busIf.dbg_req = 1'b0;
        settle();
        checkOutput("read held rdata", busIf.dbg_rdata, 32'hDEADBEEF);
        doDebug(1'b0, 5'd7, 32'd0, rd);
        checkOutput("reread x7", rd, 32'h11111111);

        // Starvation: continuous WB denies the debug write until stall_id drains the pipe.
        for (int i = 1; i <= 10; i++) begin
            stepCycle();
            applyStimulus(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b1, 1'b1, 5'd9, 32'h55AA);
            settle();
            checkOutput("starve stall", 32'(busIf.stall_id), 32'(i > STARVE_MAX));
        end
        stepCycle();
        busIf.RegWriteW = 1'b0;
        settle();
        checkOutput("starve grant addr", 32'(busIf.rf_waddr), 32'd9);
        checkOutput("starve grant data", busIf.rf_wdata, 32'h55AA);
        checkOutput("starve grant stall", 32'(busIf.stall_id), 32'd1);
        stepCycle();
        settle();
        checkOutput("starve ack", 32'(busIf.dbg_ack), 32'd1);
        checkOutput("starve released", 32'(busIf.stall_id), 32'd0);
        checkOutput("model starve", 32'(mStarve), 32'd0);
        stepCycle();
        busIf.dbg_req = 1'b0;
        settle();

        // Debug write to x0 is acknowledged but never reaches the register file.
        stepCycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd0, 32'hFFFFFFFF);
        settle();
        checkOutput("x0 rf_we", 32'(busIf.rf_we), 32'd0);
        stepCycle();
        settle();
        checkOutput("x0 ack", 32'(busIf.dbg_ack), 32'd1);
        stepCycle();
        busIf.dbg_req = 1'b0;
        settle();
        doDebug(1'b0, 5'd0, 32'd0, rd);
        checkOutput("x0 reads zero", rd, 32'd0);

        // Randomized WB, decode and debug traffic with occasional resets and WB bursts.
        active = 1'b0; sawAck = 1'b0; waitCnt = 0;
        for (int c = 0; c < 2000; c++) begin
            stepCycle();
            if (!rst) rst = 1'b1;
            else if ($urandom_range(0, 499) == 0) rst = 1'b0;
            burst = (c % 300) < 24;
            busIf.RegWriteW = burst ? 1'b1 : 1'($urandom_range(0, 1));
            busIf.RdW       = burst ? 5'($urandom_range(1, 31)) : 5'($urandom);
            busIf.ResultW   = $urandom;
            busIf.A1D       = 5'($urandom);
            if (!rst) begin
                active = 1'b0;
                busIf.dbg_req = 1'b0;
            end else if (active && sawAck) begin
                active = 1'b0;
                busIf.dbg_req = 1'b0;
            end else if (active && waitCnt >= 200) begin
                numChecks++;
                numErrors++;
                $display("[TB] FAIL dbg_ack timeout: waited %0d cycles, expected ack within 200", waitCnt);
                active = 1'b0;
                busIf.dbg_req = 1'b0;
            end else if (!active && $urandom_range(0, 2) == 0) begin
                active = 1'b1;
                waitCnt = 0;
                busIf.dbg_req   = 1'b1;
                busIf.dbg_we    = 1'($urandom_range(0, 1));
                busIf.dbg_addr  = 5'($urandom);
                busIf.dbg_wdata = $urandom;
            end
            if (active) waitCnt++;
            settle();
            sawAck = busIf.dbg_ack;
        end

        stepCycle();
        rst = 1'b1;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 40; i++) stepCycle();
        settle();
        for (int i = 0; i < 32; i++) checkOutput($sformatf("final x%0d", i), regs[i], mRegs[i]);

        $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
        $finish;
    end

endmodule
